// File: rtl/spr_line_rend.sv
// Scanline sprite renderer: per-line slot store plus a registered per-pixel priority pick.
// Optional sprite-zero hit detection is enabled by defining SPR_ZERO_HIT_EN.
module spr_line_rend #(
  parameter int unsigned NUM_SPR = 8,
  parameter int unsigned SLOT_W  = $clog2(NUM_SPR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              load,
  input  logic [31:0]       rend_buf,
  input  logic              draw,
  input  logic [7:0]        pixel_x,
  output logic [3:0]        pallete_colour,
  output logic              valid,
  output logic              bkg_priority,
  output logic [SLOT_W-1:0] slot_count,
  output logic              overflow
`ifdef SPR_ZERO_HIT_EN
  ,
  input  logic              spr0_in,
  output logic              spr0_hit
`endif
);

  logic [7:0] p0_q   [NUM_SPR];
  logic [7:0] p1_q   [NUM_SPR];
  logic [7:0] xpos_q [NUM_SPR];
  logic [1:0] pal_q  [NUM_SPR];
  logic       pri_q  [NUM_SPR];

  logic [SLOT_W-1:0] slot_count_q, slot_count_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_idx;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  always_comb begin
    wr_en        = 1'b0;
    wr_idx       = '0;
    slot_count_d = slot_count_q;
    overflow_d   = overflow_q;
    if (line_start) begin
      overflow_d   = 1'b0;
      slot_count_d = '0;
      if (load) begin
        wr_en        = 1'b1;
        slot_count_d = SLOT_W'(1);
      end
    end else if (load) begin
      if (slot_count_q == SLOT_W'(NUM_SPR)) begin
        overflow_d = 1'b1;
      end else begin
        wr_en        = 1'b1;
        wr_idx       = slot_count_q;
        slot_count_d = slot_count_q + SLOT_W'(1);
      end
    end
  end

  // Store bitmaps so pixel column c always reads bit c, whatever the flip.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SPR; i++) begin
      if (wr_en && wr_idx == SLOT_W'(i)) begin
        p0_q[i]   <= rend_buf[30] ? rend_buf[7:0]  : rev8(rend_buf[7:0]);
        p1_q[i]   <= rend_buf[30] ? rend_buf[15:8] : rev8(rend_buf[15:8]);
        xpos_q[i] <= rend_buf[23:16];
        pal_q[i]  <= rend_buf[25:24];
        pri_q[i]  <= rend_buf[29];
      end
    end
  end

  logic [8:0]         dx  [NUM_SPR];
  logic [1:0]         pix [NUM_SPR];
  logic [NUM_SPR-1:0] opq;
  logic               found;
  logic [3:0]         win_colour;
  logic               win_pri;

  // A 9-bit difference with no borrow and bits [8:3] clear means xpos <= x < xpos+8.
  always_comb begin
    found      = 1'b0;
    win_colour = '0;
    win_pri    = 1'b0;
    opq        = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      dx[i]  = {1'b0, pixel_x} - {1'b0, xpos_q[i]};
      pix[i] = {p1_q[i][dx[i][2:0]], p0_q[i][dx[i][2:0]]};
      opq[i] = draw && (SLOT_W'(i) < slot_count_q) && (dx[i][8:3] == 6'd0) && (|pix[i]);
      if (!found && opq[i]) begin
        found      = 1'b1;
        win_colour = {pal_q[i], pix[i]};
        win_pri    = pri_q[i];
      end
    end
  end

  logic [3:0] colour_q;
  logic       valid_q, pri_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_count_q <= '0;
      overflow_q   <= 1'b0;
      colour_q     <= '0;
      valid_q      <= 1'b0;
      pri_out_q    <= 1'b0;
    end else begin
      slot_count_q <= slot_count_d;
      overflow_q   <= overflow_d;
      colour_q     <= win_colour;
      valid_q      <= found;
      pri_out_q    <= win_pri;
    end
  end

  assign pallete_colour = colour_q;
  assign valid          = valid_q;
  assign bkg_priority   = pri_out_q;
  assign slot_count     = slot_count_q;
  assign overflow       = overflow_q;

`ifdef SPR_ZERO_HIT_EN
  logic spr0_flag_q, spr0_hit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      spr0_flag_q <= 1'b0;
      spr0_hit_q  <= 1'b0;
    end else begin
      if (wr_en && wr_idx == '0) spr0_flag_q <= spr0_in;
      if (line_start) begin
        spr0_hit_q <= 1'b0;
      end else if (opq[0] && spr0_flag_q && pixel_x != 8'hFF) begin
        spr0_hit_q <= 1'b1;
      end
    end
  end

  assign spr0_hit = spr0_hit_q;
`endif

endmodule

// File: tb/tb_spr_line_rend.sv
// Self-checking bench for spr_line_rend: pixel expectations are queued at drive time
// from a behavioural slot model and popped once the registered outputs appear.
module tb_spr_line_rend;
  localparam int NUM_SPR = 8;
  localparam int SLOT_W  = $clog2(NUM_SPR + 1);

  logic              clk = 1'b0;
  logic              reset, line_start, load, draw;
  logic [31:0]       rend_buf;
  logic [7:0]        pixel_x;
  logic [3:0]        pallete_colour;
  logic              valid, bkg_priority, overflow;
  logic [SLOT_W-1:0] slot_count;
`ifdef SPR_ZERO_HIT_EN
  logic              spr0_in, spr0_hit;
`endif

  spr_line_rend #(.NUM_SPR(NUM_SPR)) dut (
    .clk            (clk),
    .reset          (reset),
    .line_start     (line_start),
    .load           (load),
    .rend_buf       (rend_buf),
    .draw           (draw),
    .pixel_x        (pixel_x),
    .pallete_colour (pallete_colour),
    .valid          (valid),
    .bkg_priority   (bkg_priority),
    .slot_count     (slot_count),
    .overflow       (overflow)
`ifdef SPR_ZERO_HIT_EN
    ,
    .spr0_in        (spr0_in),
    .spr0_hit       (spr0_hit)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the slot store, kept in descriptor form.
  logic [7:0] m_x  [NUM_SPR];
  logic [7:0] m_p0 [NUM_SPR];
  logic [7:0] m_p1 [NUM_SPR];
  logic [1:0] m_pal[NUM_SPR];
  logic       m_pri[NUM_SPR];
  logic       m_hf [NUM_SPR];
  int         m_count = 0;
  logic       m_ovf = 1'b0;

  logic [5:0] exp_q[$];
  logic [5:0] got, expv;

  // {valid, bkg_priority, pallete_colour}
  function automatic logic [5:0] model_px(input logic d, input logic [7:0] x);
    logic [2:0] c, bi;
    logic       b0, b1;
    if (!d) return 6'd0;
    for (int i = 0; i < m_count; i++) begin
      if (x >= m_x[i] && int'(x) < int'(m_x[i]) + 8) begin
        c  = 3'(x - m_x[i]);
        bi = m_hf[i] ? c : 3'(7 - int'(c));
        b0 = m_p0[i][bi];
        b1 = m_p1[i][bi];
        if (b0 | b1) return {1'b1, m_pri[i], m_pal[i], b1, b0};
      end
    end
    return 6'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input logic [7:0] x, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [1:0] pal, input logic pri, input logic hf);
    if (m_count < NUM_SPR) begin
      m_x[m_count] = x; m_p0[m_count] = p0; m_p1[m_count] = p1;
      m_pal[m_count] = pal; m_pri[m_count] = pri; m_hf[m_count] = hf;
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic set_buf(input logic [7:0] x, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [1:0] pal, input logic pri, input logic hf);
    rend_buf = {1'b0, hf, pri, 3'b000, pal, x, p1, p0};
  endtask

  task automatic load_spr(input logic [7:0] x, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [1:0] pal, input logic pri, input logic hf);
    set_buf(x, p0, p1, pal, pri, hf);
    load = 1'b1;
    model_load(x, p0, p1, pal, pri, hf);
    tick();
    load = 1'b0;
  endtask

  task automatic new_line();
    line_start = 1'b1;
    m_count = 0;
    m_ovf = 1'b0;
    tick();
    line_start = 1'b0;
  endtask

  task automatic drive_px(input logic d, input logic [7:0] x);
    draw = d;
    pixel_x = x;
    exp_q.push_back(model_px(d, x));
    tick();
    draw = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid, bkg_priority, pallete_colour} !== 6'd0 || slot_count !== '0 || overflow !== 1'b0)
    begin
      errors++;
      $display("FAIL reset: out=%h cnt=%0d ovf=%b required 0/0/0",
               {valid, bkg_priority, pallete_colour}, slot_count, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    new_line();
    load_spr(8'd10, 8'hFF, 8'h00, 2'd2, 1'b0, 1'b0);
    for (int x = 0; x <= 20; x++) begin
      drive_px(1'b1, 8'(x));
      got = {valid, bkg_priority, pallete_colour};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL single x=%0d got=%h required=%h", x, got, expv);
      end
    end
    // Hard constant at the sprite body, independent of the model.
    drive_px(1'b1, 8'd13);
    void'(exp_q.pop_front());
    checks++;
    if ({valid, pallete_colour} !== 5'h19) begin
      errors++;
      $display("FAIL single_const got=%h required=19", {valid, pallete_colour});
    end
    drive_px(1'b0, 8'd12);
    got = {valid, bkg_priority, pallete_colour};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL draw_off got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_priority();
    new_line();
    load_spr(8'd20, 8'h0F, 8'h00, 2'd1, 1'b1, 1'b0);
    load_spr(8'd20, 8'hFF, 8'hFF, 2'd3, 1'b0, 1'b0);
    for (int x = 18; x <= 29; x++) begin
      drive_px(1'b1, 8'(x));
      got = {valid, bkg_priority, pallete_colour};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL priority x=%0d got=%h required=%h", x, got, expv);
      end
    end
  endtask

  task automatic test_hflip();
    for (int hf = 0; hf < 2; hf++) begin
      new_line();
      load_spr(8'd0, 8'h80, 8'h00, 2'd0, 1'b0, 1'(hf));
      for (int x = 0; x <= 8; x++) begin
        drive_px(1'b1, 8'(x));
        got = {valid, bkg_priority, pallete_colour};
        expv = exp_q.pop_front();
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL hflip%0d x=%0d got=%h required=%h", hf, x, got, expv);
        end
      end
    end
  endtask

  task automatic test_overflow();
    new_line();
    for (int i = 0; i < NUM_SPR; i++) load_spr(8'(100 + i), 8'h01, 8'h00, 2'd0, 1'b0, 1'b0);
    checks++;
    if (slot_count !== SLOT_W'(m_count) || overflow !== m_ovf) begin
      errors++;
      $display("FAIL full: cnt=%0d ovf=%b required %0d/%b", slot_count, overflow, m_count, m_ovf);
    end
    load_spr(8'd200, 8'hFF, 8'hFF, 2'd3, 1'b0, 1'b0);
    checks++;
    if (slot_count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: cnt=%0d ovf=%b required 8/1", slot_count, overflow);
    end
    drive_px(1'b1, 8'd201);
    got = {valid, bkg_priority, pallete_colour};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL dropped_slot got=%h required=%h", got, expv);
    end
    new_line();
    checks++;
    if (slot_count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL line_clear: cnt=%0d ovf=%b required 0/0", slot_count, overflow);
    end
    line_start = 1'b1;
    set_buf(8'd60, 8'hFF, 8'h00, 2'd2, 1'b1, 1'b0);
    load = 1'b1;
    m_count = 0;
    model_load(8'd60, 8'hFF, 8'h00, 2'd2, 1'b1, 1'b0);
    tick();
    line_start = 1'b0;
    load = 1'b0;
    checks++;
    if (slot_count !== SLOT_W'(1)) begin
      errors++;
      $display("FAIL line_and_load: cnt=%0d required 1", slot_count);
    end
    drive_px(1'b1, 8'd61);
    got = {valid, bkg_priority, pallete_colour};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL line_and_load_px got=%h required=%h", got, expv);
    end
  endtask

  task automatic test_wrap();
    new_line();
    load_spr(8'd252, 8'hFF, 8'hFF, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      drive_px(1'b1, 8'(250 + k));
      got = {valid, bkg_priority, pallete_colour};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL wrap x=%0d got=%h required=%h", 8'(250 + k), got, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    new_line();
    draw = 1'b1;
    pixel_x = 8'd50;
    exp_q.push_back(model_px(1'b1, 8'd50));
    set_buf(8'd48, 8'hFF, 8'hFF, 2'd1, 1'b1, 1'b0);
    load = 1'b1;
    model_load(8'd48, 8'hFF, 8'hFF, 2'd1, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got = {valid, bkg_priority, pallete_colour};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL load_during_draw step%0d got=%h required=%h", k, got, expv);
      end
      if (k == 0) drive_px(1'b1, 8'd51);
    end
  endtask

  task automatic test_reset_mid();
    new_line();
    load_spr(8'd30, 8'hFF, 8'hFF, 2'd2, 1'b0, 1'b0);
    drive_px(1'b1, 8'd32);
    got = {valid, bkg_priority, pallete_colour};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL pre_reset got=%h required=%h", got, expv);
    end
    reset = 1'b1; line_start = 1'b1; load = 1'b1; draw = 1'b1; pixel_x = 8'd33;
    tick();
    reset = 1'b0; line_start = 1'b0; load = 1'b0; draw = 1'b0;
    m_count = 0;
    m_ovf = 1'b0;
    checks++;
    if ({valid, bkg_priority, pallete_colour} !== 6'd0 || slot_count !== '0 || overflow !== 1'b0)
    begin
      errors++;
      $display("FAIL reset_mid: out=%h cnt=%0d required 0/0",
               {valid, bkg_priority, pallete_colour}, slot_count);
    end
    drive_px(1'b1, 8'd33);
    got = {valid, bkg_priority, pallete_colour};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL post_reset got=%h required=%h", got, expv);
    end
  endtask

`ifdef SPR_ZERO_HIT_EN
  task automatic test_spr0_hit();
    new_line();
    spr0_in = 1'b1;
    load_spr(8'd248, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0);
    spr0_in = 1'b0;
    for (int x = 248; x <= 255; x++) begin
      drive_px(1'b1, 8'(x));
      void'(exp_q.pop_front());
    end
    checks++;
    if (spr0_hit !== 1'b0) begin
      errors++;
      $display("FAIL spr0_x255 got=%b required 0", spr0_hit);
    end
    new_line();
    spr0_in = 1'b1;
    load_spr(8'd100, 8'h80, 8'h00, 2'd0, 1'b0, 1'b0);
    spr0_in = 1'b0;
    drive_px(1'b1, 8'd99);
    void'(exp_q.pop_front());
    checks++;
    if (spr0_hit !== 1'b0) begin
      errors++;
      $display("FAIL spr0_early got=%b required 0", spr0_hit);
    end
    drive_px(1'b1, 8'd100);
    void'(exp_q.pop_front());
    checks++;
    if (spr0_hit !== 1'b1) begin
      errors++;
      $display("FAIL spr0_set got=%b required 1", spr0_hit);
    end
    drive_px(1'b1, 8'd110);
    void'(exp_q.pop_front());
    checks++;
    if (spr0_hit !== 1'b1) begin
      errors++;
      $display("FAIL spr0_hold got=%b required 1", spr0_hit);
    end
    new_line();
    checks++;
    if (spr0_hit !== 1'b0) begin
      errors++;
      $display("FAIL spr0_clear got=%b required 0", spr0_hit);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; line_start = 1'b0; load = 1'b0; draw = 1'b0;
    rend_buf = '0; pixel_x = '0;
`ifdef SPR_ZERO_HIT_EN
    spr0_in = 1'b0;
`endif
    test_reset();
    test_single();
    test_priority();
    test_hflip();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef SPR_ZERO_HIT_EN
    test_spr0_hit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/spr_line_rend.md
# spr_line_rend

Multi-slot scanline sprite renderer. It holds up to `NUM_SPR` sprite descriptors for the current scanline and, for each pixel position presented by the PPU timing chain, outputs one 4-bit palette colour from the highest-priority opaque sprite. It sits between the OAM evaluation logic, which loads descriptors during horizontal blank, and the background/sprite pixel multiplexer, which consumes `pallete_colour`, `valid` and `bkg_priority`.

## Interface
Parameters:
- `NUM_SPR`, 8: number of sprite slots (1–16).
- `SLOT_W`, `$clog2(NUM_SPR+1)`: width of the slot counter.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `line_start` in 1: clears all slots for a new scanline.
- `load` in 1: strobe that writes `rend_buf` into the next free slot.
- `rend_buf` in 32: sprite descriptor. `[7:0]` plane 0, `[15:8]` plane 1, `[23:16]` xpos, `[25:24]` palette, `[29]` priority (1 = behind background), `[30]` hflip. Bit 7/15 is the leftmost pixel when `hflip`=0.
- `draw` in 1: pixel strobe; `pixel_x` is sampled when this is high.
- `pixel_x` in 8: current screen x.
- `pallete_colour` out 4: `{palette, plane1_bit, plane0_bit}` of the winning sprite.
- `valid` out 1: `pallete_colour` holds an opaque sprite pixel.
- `bkg_priority` out 1: priority bit of the winning sprite.
- `slot_count` out `SLOT_W`: number of slots currently loaded.
- `overflow` out 1: a load was dropped because all slots were full. Sticky until `line_start` or `reset`.
- `spr0_hit` out 1: present only with `SPR_ZERO_HIT_EN`. See Configuration.

## Operation
- Slot store:
  - A `load` writes slot `slot_count` and increments `slot_count`.
  - When `slot_count == NUM_SPR`, the load is dropped, `overflow` is set, and the count is unchanged.
  - hflip is resolved at load time: the stored bitmap is bit-reversed per plane when `hflip`=0. Pixel column c then always reads stored bit c.
- `line_start`:
  - Sets `slot_count` to 0 and clears `overflow`.
  - Slot contents need not be cleared; slots with index ≥ `slot_count` are ignored.
- `line_start` and `load` in the same cycle: the clear applies first, the descriptor goes into slot 0, and `slot_count` becomes 1.
- Pixel evaluation, per slot i < `slot_count`:
  - The slot hits if `pixel_x` ≥ xpos and `pixel_x` < xpos+8. Compute xpos+8 in 9 bits, so there is no wrap: xpos=252 covers 252–255 only.
  - Column = `pixel_x` − xpos (3 bits).
  - The pixel is opaque when its 2-bit value is not 0.
- Winner: the lowest-index opaque hit. Slot order equals OAM order.
- No opaque hit, or `draw`=0 → `valid`=0, `pallete_colour`=0, `bkg_priority`=0.
- `load` during active `draw` is legal: the new slot takes part from the next cycle's evaluation.

## Timing
- Reset: `pallete_colour`=0, `valid`=0, `bkg_priority`=0, `slot_count`=0, `overflow`=0, `spr0_hit`=0. Reset overrides `line_start` and `load` in the same cycle.
- Load to usable: a descriptor loaded at edge N participates in evaluation sampled at edge N+1.
- Pixel latency is exactly 1 cycle: `draw`/`pixel_x` sampled at edge N → outputs valid after edge N. The output stage is registered, with no combinational path from inputs to outputs.
- `draw` deasserted at edge N → `valid`=0 after edge N.
- `overflow` rises in the cycle after the dropped load.
- Reset mid-line: all slots are invalidated immediately, and outputs are 0 after the reset edge.

## Configuration
- `SPR_ZERO_HIT_EN` defined:
  - Adds `spr0_hit` and a flag recording that slot 0 was loaded from OAM entry 0. That flag is captured on the first load after `line_start`, using an extra input `spr0_in` (1 bit).
  - `spr0_hit` is sticky. It sets, with the same 1-cycle latency as the pixel outputs, when `draw`=1, slot 0 is opaque at `pixel_x`, and `pixel_x` ≠ 255. It is cleared by `reset` or `line_start`.
- Not defined: the `spr0_hit` and `spr0_in` ports and their logic are absent.

## Test plan
- Reset, then load xpos=10, planes 8'hFF/8'h00, palette 2, hflip=0; sweep `draw` over x=0..20 → `valid`=1 for x=10..17 only, `pallete_colour`=4'h9, one cycle after each sample.
- Load slot 0 at xpos=20 with planes 8'h0F/8'h00 and slot 1 at xpos=20 with planes 8'hFF/8'hFF, palette 3 → x=20..23 give 4'hF (slot 1, because slot 0 is transparent there); x=24..27 give slot 0's colour.
- Load plane0=8'h80, hflip=0, xpos=0 → opaque only at x=0; reload with hflip=1 → opaque only at x=7.
- With `NUM_SPR`=8, issue 9 loads → `slot_count`=8, `overflow`=1; `line_start` → `slot_count`=0, `overflow`=0. `line_start` and `load` in the same cycle → `slot_count`=1.
- xpos=252 → `valid` at x=252..255; x=0..3 show no wrap.
- `SPR_ZERO_HIT_EN`: slot 0 opaque at x=255 only → `spr0_hit` stays 0; opaque at x=100 → `spr0_hit`=1 one cycle later and holds until `line_start`.
